// File: rtl/cpu_fetch_pkg.sv
// Shared fetch-side types and constants for the pre-IF sequencer.
package cpu_fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] FETCH_RESET_PC = 32'h1c00_0000;

  typedef enum logic [1:0] {
    FS_REQ  = 2'd0,
    FS_WAIT = 2'd1,
    FS_HOLD = 2'd2
  } fetch_state_e;

  // Numeric order doubles as priority: smaller non-zero value is more urgent.
  typedef enum logic [2:0] {
    RD_NONE    = 3'd0,
    RD_EX      = 3'd1,
    RD_ERTN    = 3'd2,
    RD_REFETCH = 3'd3,
    RD_BR      = 3'd4
  } redirect_src_e;

  // True when redirect a is at least as urgent as redirect b.
  function automatic logic outranks(input redirect_src_e a, input redirect_src_e b);
    return (a != RD_NONE) && (a <= b);
  endfunction

endpackage

// File: rtl/redirect_arb.sv
// Fixed-priority selection of the redirect source for the current cycle.
module redirect_arb
  import cpu_fetch_pkg::*;
(
  input  logic            wb_ex_i,
  input  logic [XLEN-1:0] ex_entry_i,
  input  logic            wb_ertn_i,
  input  logic [XLEN-1:0] era_i,
  input  logic            wb_refetch_i,
  input  logic [XLEN-1:0] refetch_pc_i,
  input  logic            br_taken_i,
  input  logic [XLEN-1:0] br_target_i,
  output logic            redirect_valid_c,
  output redirect_src_e   redirect_src_c,
  output logic [XLEN-1:0] redirect_target_c
);

  // WB sources beat the EX branch; among WB, exception > ertn > refetch.
  always_comb begin
    redirect_valid_c  = 1'b1;
    redirect_src_c    = RD_NONE;
    redirect_target_c = '0;
    if (wb_ex_i) begin
      redirect_src_c    = RD_EX;
      redirect_target_c = ex_entry_i;
    end else if (wb_ertn_i) begin
      redirect_src_c    = RD_ERTN;
      redirect_target_c = era_i;
    end else if (wb_refetch_i) begin
      redirect_src_c    = RD_REFETCH;
      redirect_target_c = refetch_pc_i;
    end else if (br_taken_i) begin
      redirect_src_c    = RD_BR;
      redirect_target_c = br_target_i;
    end else begin
      redirect_valid_c  = 1'b0;
    end
  end

endmodule

// File: rtl/fetch_req_ctrl.sv
// Pre-IF fetch sequencer: owns the fetch PC, issues one instruction-bus
// request at a time, and hands responses to IF unless they were cancelled.
module fetch_req_ctrl
  import cpu_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = FETCH_RESET_PC
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            wb_ex,
  input  logic [XLEN-1:0] ex_entry,
  input  logic            wb_ertn,
  input  logic [XLEN-1:0] era,
  input  logic            wb_refetch,
  input  logic [XLEN-1:0] refetch_pc,
  input  logic            br_taken,
  input  logic [XLEN-1:0] br_target,
  input  logic            if_allow_in,
  output logic            inst_sram_req,
  output logic [XLEN-1:0] inst_sram_addr,
  input  logic            inst_sram_addr_ok,
  input  logic            inst_sram_data_ok,
  input  logic [XLEN-1:0] inst_sram_rdata,
  output logic            if_valid,
  output logic [XLEN-1:0] if_pc,
  output logic [XLEN-1:0] if_inst
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic            pend_q, pend_d;
  redirect_src_e   pend_src_q, pend_src_d;
  logic [XLEN-1:0] pend_target_q, pend_target_d;
  logic            cancel_q, cancel_d;
  logic            if_valid_q, if_valid_d;
  logic [XLEN-1:0] if_pc_q, if_pc_d;
  logic [XLEN-1:0] if_inst_q, if_inst_d;

  logic            rd_valid_c;
  redirect_src_e   rd_src_c;
  logic [XLEN-1:0] rd_target_c;

  logic            take_new_c;
  logic            newest_valid_c;
  redirect_src_e   newest_src_c;
  logic [XLEN-1:0] newest_target_c;

  redirect_arb u_redirect_arb (
    .wb_ex_i           (wb_ex),
    .ex_entry_i        (ex_entry),
    .wb_ertn_i         (wb_ertn),
    .era_i             (era),
    .wb_refetch_i      (wb_refetch),
    .refetch_pc_i      (refetch_pc),
    .br_taken_i        (br_taken),
    .br_target_i       (br_target),
    .redirect_valid_c  (rd_valid_c),
    .redirect_src_c    (rd_src_c),
    .redirect_target_c (rd_target_c)
  );

  // Newest redirect: an incoming one replaces the pending one unless it is less urgent.
  assign take_new_c      = rd_valid_c && (!pend_q || outranks(rd_src_c, pend_src_q));
  assign newest_valid_c  = pend_q || rd_valid_c;
  assign newest_src_c    = take_new_c ? rd_src_c    : pend_src_q;
  assign newest_target_c = take_new_c ? rd_target_c : pend_target_q;

  assign inst_sram_req  = (state_q == FS_REQ);
  assign inst_sram_addr = fetch_pc_q;
  assign if_valid       = if_valid_q;
  assign if_pc          = if_pc_q;
  assign if_inst        = if_inst_q;

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= FS_REQ;
      fetch_pc_q    <= RESET_PC;
      req_pc_q      <= '0;
      pend_q        <= 1'b0;
      pend_src_q    <= RD_NONE;
      pend_target_q <= '0;
      cancel_q      <= 1'b0;
      if_valid_q    <= 1'b0;
      if_pc_q       <= '0;
      if_inst_q     <= '0;
    end else begin
      state_q       <= state_d;
      fetch_pc_q    <= fetch_pc_d;
      req_pc_q      <= req_pc_d;
      pend_q        <= pend_d;
      pend_src_q    <= pend_src_d;
      pend_target_q <= pend_target_d;
      cancel_q      <= cancel_d;
      if_valid_q    <= if_valid_d;
      if_pc_q       <= if_pc_d;
      if_inst_q     <= if_inst_d;
    end
  end

  // Next-state, redirect capture and output-buffer update.
  always_comb begin
    state_d       = state_q;
    fetch_pc_d    = fetch_pc_q;
    req_pc_d      = req_pc_q;
    pend_d        = pend_q;
    pend_src_d    = pend_src_q;
    pend_target_d = pend_target_q;
    cancel_d      = cancel_q;
    if_valid_d    = if_valid_q;
    if_pc_d       = if_pc_q;
    if_inst_d     = if_inst_q;

    unique case (state_q)
      FS_REQ: begin
        if (inst_sram_addr_ok) begin
          // Accepted address is stale if any redirect is known by now.
          state_d    = FS_WAIT;
          req_pc_d   = fetch_pc_q;
          cancel_d   = newest_valid_c;
          fetch_pc_d = newest_valid_c ? newest_target_c : fetch_pc_q + XLEN'(4);
          pend_d     = 1'b0;
          pend_src_d = RD_NONE;
        end else if (rd_valid_c) begin
          pend_d        = 1'b1;
          pend_src_d    = newest_src_c;
          pend_target_d = newest_target_c;
        end
      end
      FS_WAIT: begin
        if (inst_sram_data_ok) begin
          if (cancel_q || rd_valid_c) begin
            state_d  = FS_REQ;
            cancel_d = 1'b0;
            if (newest_valid_c) fetch_pc_d = newest_target_c;
            pend_d     = 1'b0;
            pend_src_d = RD_NONE;
          end else begin
            state_d    = FS_HOLD;
            if_valid_d = 1'b1;
            if_pc_d    = req_pc_q;
            if_inst_d  = inst_sram_rdata;
          end
        end else if (rd_valid_c) begin
          cancel_d      = 1'b1;
          pend_d        = 1'b1;
          pend_src_d    = newest_src_c;
          pend_target_d = newest_target_c;
        end
      end
      FS_HOLD: begin
        // A redirect squashes the buffered instruction and retargets directly.
        if (rd_valid_c) begin
          state_d    = FS_REQ;
          if_valid_d = 1'b0;
          fetch_pc_d = rd_target_c;
        end else if (if_allow_in) begin
          state_d    = FS_REQ;
          if_valid_d = 1'b0;
        end
      end
      default: state_d = FS_REQ;
    endcase
  end

endmodule

// File: doc/fetch_req_ctrl.md
Name: fetch_req_ctrl

Overview:
- Pre-IF fetch sequencer for the pipelined CPU.
- Owns the fetch PC and drives the SRAM-like instruction bus (req/addr_ok/data_ok), one request outstanding at a time.
- Arbitrates redirect sources: WB exception, WB ertn, WB TLB refetch, and EX branch.
- Hands fetched instructions to the IF stage with a valid/allow_in handshake, and discards responses belonging to cancelled fetches.

Parameters:
RESET_PC, 32'h1c000000, first fetch address after reset

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
wb_ex  in  1  exception redirect, one-cycle pulse
ex_entry  in  32  exception entry address
wb_ertn  in  1  ertn redirect, one-cycle pulse
era  in  32  ertn return address
wb_refetch  in  1  TLB/CSR refetch redirect, one-cycle pulse
refetch_pc  in  32  refetch address
br_taken  in  1  branch redirect, one-cycle pulse
br_target  in  32  branch target
if_allow_in  in  1  IF stage can accept an instruction this cycle
inst_sram_req  out  1  bus request
inst_sram_addr  out  32  request address
inst_sram_addr_ok  in  1  request accepted
inst_sram_data_ok  in  1  response valid
inst_sram_rdata  in  32  response data
if_valid  out  1  instruction valid to IF
if_pc  out  32  PC of the delivered instruction
if_inst  out  32  delivered instruction

Behaviour:
- Reset (rst high at a clk edge):
  - state=REQ, fetch_pc=RESET_PC.
  - redirect_pending=0, cancel=0.
  - if_valid=0, if_pc=0, if_inst=0.
  - inst_sram_req=1 from the first cycle after reset.
  - Reset mid-transaction clears all state. A later data_ok for the pre-reset request is not tracked and is ignored, because state is REQ.
- Redirect arbitration: fixed priority wb_ex > wb_ertn > wb_refetch > br_taken. Exactly one target is selected per cycle. A WB source in the same cycle as a branch overrides the branch.
- Redirect capture:
  - A redirect in any cycle writes pend_target and sets redirect_pending=1.
  - A later, higher-or-equal-priority redirect overwrites the pending one.
  - A branch never overwrites a pending WB redirect.
- States:
  - REQ: inst_sram_req=1, inst_sram_addr=fetch_pc. Addr is held stable until addr_ok, even if a redirect arrives.
    - On addr_ok → WAIT.
    - cancel is set if a redirect is pending or arrives in the same cycle.
    - fetch_pc <= newest redirect target if any, else fetch_pc+4. redirect_pending then clears.
  - WAIT: req=0.
    - On data_ok with cancel=1 or a same-cycle redirect: drop data, clear cancel → REQ.
    - On data_ok otherwise: latch rdata and PC into out buffer, if_valid=1 → HOLD.
    - A redirect without data_ok sets cancel=1.
  - HOLD: if_valid=1, req=0.
    - When if_allow_in=1, the instruction is consumed → REQ with if_valid=0 next cycle.
    - A redirect in HOLD clears if_valid next cycle (buffer squashed) → REQ. The redirect is applied to fetch_pc immediately, not via pending.
- Latency: addr_ok in cycle N, data_ok in cycle M → if_valid in cycle M+1. With if_allow_in=1, the next req is asserted in cycle M+2.
- If the bus returns data_ok in the same cycle as addr_ok for a new request, the protocol forbids it. A bus that does so is non-conforming and behaviour is undefined.
- PC arithmetic is 32-bit with wrap-around; 32'hfffffffc+4 = 0. No alignment check is done here; the ADEF exception is generated downstream.

Decomposition:
- Shared package cpu_fetch_pkg:
  - RESET_PC constant.
  - fetch state encoding (REQ, WAIT, HOLD).
  - redirect source encoding (NONE, EX, ERTN, REFETCH, BR).
- Sub-module redirect_arb: combinational priority mux producing redirect_valid, redirect_src and redirect_target.

Test Plan:
- Reset, bus answers addr_ok/data_ok one cycle each, if_allow_in=1 → addresses 1c000000, 1c000004, 1c000008 delivered in order, with if_pc matching.
- br_taken to 1c000100 while in WAIT for 1c000004 → that response is dropped (if_valid stays 0); next request addr=1c000100.
- wb_ex (ex_entry=1c008000) and br_taken (1c000200) in the same cycle → next request addr=1c008000.
- br_taken (1c000200), then wb_ertn (era=1c000050) one cycle later, both while req stalled without addr_ok → addr held stable, cancel set on acceptance, next addr=1c000050.
- if_allow_in=0 for 5 cycles in HOLD → if_valid held, if_inst and if_pc stable, no new req; on release, one delivery and then req resumes.
- rst asserted in WAIT, then a stray data_ok → no if_valid; first request after reset is addr=1c000000.
